gamma_lut_pipe: RTL

GAMMA_LUT_PIPE -- requirements
Module: gamma_lut_pipe

---
 rtl/gamma_lut_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gamma_lut_pipe.sv
// Per-channel gamma LUT on a 2-cycle video pipeline, with double-buffered banks that swap on
// the next vsync rising edge after a request. After reset every LUT is rewritten to identity.
module gamma_lut_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_NUM = 3,
  localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int unsigned PIX_W = CH_NUM * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_vsync,
  input  logic              pre_hsync,
  input  logic              pre_de,
  input  logic [PIX_W-1:0]  pre_data,
  input  logic              bypass,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DATA_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_swap,
  output logic              cfg_ready,
  output logic              swap_pending,
  output logic              active_bank,
  output logic              post_vsync,
  output logic              post_hsync,
  output logic              post_de,
  output logic [PIX_W-1:0]  post_data
);

  localparam int unsigned Depth = 2 ** DATA_W;

  typedef enum logic [1:0] {StInit, StRun, StSwapWait} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic                bank_q, bank_d;
  logic                vs_prev_q, vs_prev_d;

  logic [CH_NUM-1:0][1:0] wr_en;
  logic [DATA_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;

  logic [DATA_W-1:0] lut_mem [CH_NUM][2][Depth];

  logic              s1_vs_q, s1_vs_d, s1_hs_q, s1_hs_d, s1_de_q, s1_de_d;
  logic              s1_byp_q, s1_byp_d, s1_bank_q, s1_bank_d;
  logic [PIX_W-1:0]  s1_pix_q, s1_pix_d;
  logic              s2_vs_q, s2_vs_d, s2_hs_q, s2_hs_d, s2_de_q, s2_de_d;
  logic [PIX_W-1:0]  s2_pix_q, s2_pix_d;
  logic [PIX_W-1:0]  lut_rd;

  logic vs_rise;
  assign vs_rise = pre_vsync & ~vs_prev_q;

  // Control FSM and LUT write port
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    vs_prev_d = pre_vsync;
    wr_en     = '0;
    wr_addr   = cfg_addr;
    wr_data   = cfg_data;
    unique case (state_q)
      StInit: begin
        wr_en   = '1;
        wr_addr = cnt_q;
        wr_data = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = StRun;
      end
      StRun: begin
        for (int c = 0; c < CH_NUM; c++) begin
          if (cfg_we && (cfg_ch == CH_W'(c))) wr_en[c][~bank_q] = 1'b1;
        end
        // A vsync edge coinciding with the request is deliberately not acted on.
        if (cfg_swap) state_d = StSwapWait;
      end
      StSwapWait: begin
        if (vs_rise) begin
          bank_d  = ~bank_q;
          state_d = StRun;
        end
      end
      default: state_d = StInit;
    endcase
    if (rst) wr_en = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      bank_q    <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (wr_en[c][b]) lut_mem[c][b][wr_addr] <= wr_data;
      end
    end
  end

  // Stage 1 captures the pixel together with its bypass decision and lookup bank.
  always_comb begin
    s1_vs_d   = pre_vsync;
    s1_hs_d   = pre_hsync;
    s1_de_d   = pre_de;
    s1_pix_d  = pre_data;
    s1_byp_d  = bypass | (state_q == StInit);
    s1_bank_d = bank_q;
  end

  always_comb begin
    lut_rd = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      lut_rd[c*DATA_W +: DATA_W] = lut_mem[c][s1_bank_q][s1_pix_q[c*DATA_W +: DATA_W]];
    end
  end

  always_comb begin
    s2_vs_d  = s1_vs_q;
    s2_hs_d  = s1_hs_q;
    s2_de_d  = s1_de_q;
    s2_pix_d = '0;
    if (s1_de_q) s2_pix_d = s1_byp_q ? s1_pix_q : lut_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vs_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_byp_q  <= 1'b0;
      s1_bank_q <= 1'b0;
      s1_pix_q  <= '0;
      s2_vs_q   <= 1'b0;
      s2_hs_q   <= 1'b0;
      s2_de_q   <= 1'b0;
      s2_pix_q  <= '0;
    end else begin
      s1_vs_q   <= s1_vs_d;
      s1_hs_q   <= s1_hs_d;
      s1_de_q   <= s1_de_d;
      s1_byp_q  <= s1_byp_d;
      s1_bank_q <= s1_bank_d;
      s1_pix_q  <= s1_pix_d;
      s2_vs_q   <= s2_vs_d;
      s2_hs_q   <= s2_hs_d;
      s2_de_q   <= s2_de_d;
      s2_pix_q  <= s2_pix_d;
    end
  end

  assign cfg_ready    = (state_q == StRun);
  assign swap_pending = (state_q == StSwapWait);
  assign active_bank  = bank_q;
  assign post_vsync   = s2_vs_q;
  assign post_hsync   = s2_hs_q;
  assign post_de      = s2_de_q;
  assign post_data    = s2_pix_q;

endmodule
